load_store_unit: RTL and testbench

Initiator side of the data-memory port: accepts one load or store per handshake from the execute/memory stage, then performs it as a sequence of single-byte accesses on an 8-bit-wide data memory. Loads are assembled little-endian and sign- or zero-extended per RISC-V `funct3`. The unit sits between the pipeline's memory stage and the byte-addressed data memory, and is the only master of that memory.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundles the request/response handshake and the byte-wide data-memory port
// of the load/store unit.
//   slave  : the load_store_unit side (takes requests, drives the memory port)
//   master : the environment side (pipeline memory stage plus the data memory)
// Signals: req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata (request),
//          resp_valid/resp_err/resp_rdata (completion),
//          mem_re/mem_we/mem_addr/mem_wdata/mem_rdata (byte memory port).
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load or store per handshake and performs
// it as N single-byte accesses on an 8-bit data memory. Loads are assembled
// little-endian and sign/zero-extended; illegal funct3 gives an error response
// without touching memory.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset (also gates strobes/handshake outputs)
//   bus    : load_store_unit_if.slave (request, response and memory port)
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned halfword
// and word accesses with an error response.
module load_store_unit #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StXfer, StDrain, StResp} state_e;

    state_e            state_q;
    logic              ready_q;
    logic              we_q;
    logic              uns_q;
    logic [2:0]        n_q;
    logic [2:0]        cnt_q;      // number of byte strobes issued so far
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       result_q;
    logic              cap_q;      // mem_rdata carries a byte this cycle
    logic [1:0]        cap_idx_q;  // ... and this is its byte index
    logic              mem_re_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;

    logic              req_legal;
    logic [2:0]        req_n;
    logic [31:0]       assembled;
    logic [31:0]       extended;
    logic              sign_bit;

    always_comb begin
        case (bus.req_funct3[1:0])
            2'b00:   req_n = 3'd1;
            2'b01:   req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
        if (bus.req_we) begin
            req_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            req_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
`ifdef LSU_ALIGN_CHECK_EN
        if ((req_n == 3'd2 && bus.req_addr[0]) ||
            (req_n == 3'd4 && bus.req_addr[1:0] != 2'b00)) begin
            req_legal = 1'b0;
        end
`endif
    end

    // Result including the byte arriving this cycle; in DRAIN this is the final byte.
    always_comb begin
        assembled = result_q;
        if (cap_q) begin
            assembled[{cap_idx_q, 3'b000} +: 8] = bus.mem_rdata;
        end
        sign_bit = 1'b0;
        extended = assembled;
        case (n_q)
            3'd1: begin
                sign_bit = assembled[7] & ~uns_q;
                extended = {{24{sign_bit}}, assembled[7:0]};
            end
            3'd2: begin
                sign_bit = assembled[15] & ~uns_q;
                extended = {{16{sign_bit}}, assembled[15:0]};
            end
            default: extended = assembled;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            n_q          <= 3'd0;
            cnt_q        <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            result_q     <= 32'd0;
            cap_q        <= 1'b0;
            cap_idx_q    <= 2'd0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            cap_q        <= mem_re_q;
            cap_idx_q    <= cnt_q[1:0] - 2'd1;
            result_q     <= assembled;
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (ready_q && bus.req_valid) begin
                        ready_q  <= 1'b0;
                        we_q     <= bus.req_we;
                        uns_q    <= bus.req_funct3[2];
                        n_q      <= req_n;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        result_q <= 32'd0;
                        if (req_legal) begin
                            // Byte 0 goes out straight away so strobes occupy cycles 1..N.
                            state_q    <= StXfer;
                            cnt_q      <= 3'd1;
                            mem_addr_q <= bus.req_addr;
                            if (bus.req_we) begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= bus.req_wdata[7:0];
                            end else begin
                                mem_re_q <= 1'b1;
                            end
                        end else begin
                            state_q      <= StResp;
                            cnt_q        <= 3'd0;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end
                    end
                end
                StXfer: begin
                    if (cnt_q < n_q) begin
                        cnt_q      <= cnt_q + 3'd1;
                        mem_addr_q <= addr_q + ADDR_W'(cnt_q);
                        if (we_q) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        end else begin
                            mem_re_q <= 1'b1;
                        end
                    end else if (we_q) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                    end else begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    state_q      <= StResp;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= extended;
                end
                StResp: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gating with rst_ni makes a reset abort the in-flight strobe at once.
    assign bus.req_ready  = ready_q & rst_ni;
    assign bus.resp_valid = resp_valid_q & rst_ni;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_re     = mem_re_q & rst_ni;
    assign bus.mem_we     = mem_we_q & rst_ni;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(8)) bus ();
    load_store_unit #(.ADDR_W(8)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    typedef struct packed {
        logic        re;
        logic        we;
        logic        rv;
        logic        err;
        logic        rdy;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [31:0] rdata;
    } rec_t;

    rec_t        exp_q[$];
    logic [7:0]  mem  [256];
    logic [7:0]  gmem [256];
    logic [7:0]  last_addr = 8'd0;
    logic [7:0]  last_wdata = 8'd0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;
    bit          chk_en = 1'b0;
    bit          load_mem = 1'b1;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: synchronous write, read data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= gmem[i];
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        else            bus.mem_rdata <= 8'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rec_t idle_rec(input logic rdy);
        rec_t r;
        r       = '0;
        r.rdy   = rdy;
        r.addr  = last_addr;
        r.wdata = last_wdata;
        return r;
    endfunction

    // Per-cycle compare against the expected schedule.
    always @(negedge clk) begin
        rec_t e;
        if (chk_en) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else                   e = idle_rec(1'b1);
            chk("req_ready", bus.req_ready, e.rdy);
            chk("mem_re", bus.mem_re, e.re);
            chk("mem_we", bus.mem_we, e.we);
            chk("re_we_excl", bus.mem_re & bus.mem_we, 0);
            chk("mem_addr", bus.mem_addr, e.addr);
            chk("mem_wdata", bus.mem_wdata, e.wdata);
            chk("resp_valid", bus.resp_valid, e.rv);
            if (e.rv) begin
                chk("resp_err", bus.resp_err, e.err);
                chk("resp_rdata", bus.resp_rdata, e.rdata);
            end
            if (bus.resp_valid) begin
                last_rdata = bus.resp_rdata;
                last_err   = bus.resp_err;
            end
        end
    end

    task automatic issue(input bit we, input bit [2:0] f3, input bit [7:0] a,
                         input bit [31:0] wd, input bit abort);
        int          n;
        int          g;
        bit          legal;
        rec_t        r;
        logic [31:0] v;
        logic [31:0] sh;
        g = 0;
        @(negedge clk);
        while (exp_q.size() != 0 || !bus.req_ready) begin
            @(negedge clk);
            g++;
            if (g > 100) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: got req_ready=%b want 1 within 100 cycles", bus.req_ready);
                exp_q.delete();
                break;
            end
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = 8'($urandom);
        bus.req_wdata  = $urandom;
        case (f3)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        legal = (n != 0) && !(we && f3 > 3'd2);
`ifdef LSU_ALIGN_CHECK_EN
        if ((n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0)) legal = 1'b0;
`endif
        if (!legal) begin
            r = idle_rec(1'b0);
            r.rv = 1'b1;
            r.err = 1'b1;
            exp_q.push_back(r);
            exp_q.push_back(idle_rec(1'b1));
        end else if (we) begin
            for (int j = 0; j < n; j++) begin
                sh = wd >> (8 * j);
                last_addr  = 8'(a + j);
                last_wdata = sh[7:0];
                gmem[last_addr] = last_wdata;
                r = idle_rec(1'b0);
                r.we = 1'b1;
                exp_q.push_back(r);
                if (abort) break;
            end
            if (!abort) begin
                r = idle_rec(1'b0);
                r.rv = 1'b1;
                exp_q.push_back(r);
                exp_q.push_back(idle_rec(1'b1));
            end
        end else begin
            v = 32'd0;
            for (int j = 0; j < n; j++) begin
                last_addr = 8'(a + j);
                v = v | (32'(gmem[last_addr]) << (8 * j));
                r = idle_rec(1'b0);
                r.re = 1'b1;
                exp_q.push_back(r);
            end
            if (f3[2] == 1'b0 && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            exp_q.push_back(idle_rec(1'b0));
            r = idle_rec(1'b0);
            r.rv = 1'b1;
            r.rdata = v;
            exp_q.push_back(r);
            exp_q.push_back(idle_rec(1'b1));
        end
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            g++;
            if (g > 100) begin
                total++;
                bad++;
                $display("FAIL done_timeout: got %0d pending want 0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        exp_q.delete();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_strobes", {bus.mem_re, bus.mem_we}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        last_addr  = 8'd0;
        last_wdata = 8'd0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", bus.req_ready, 1);
        chk_en = 1'b1;
    endtask

    initial begin
        logic [7:0] s21;
        logic [7:0] s22;
        logic [7:0] s23;
        logic [7:0] s31;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 8'd0;
        bus.req_wdata  = 32'd0;
        for (int i = 0; i < 256; i++) gmem[i] = 8'($urandom);
        @(posedge clk);
        #1;
        load_mem = 1'b0;
        apply_reset(3);

        issue(1, 3'd2, 8'h10, 32'hDEADBEEF, 0);
        wait_done();
        chk("sw_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
        chk("sw_err", last_err, 0);
        issue(0, 3'd2, 8'h10, 32'h0, 0);
        wait_done();
        chk("lw_lit", last_rdata, 32'hDEADBEEF);
        issue(0, 3'd1, 8'h12, 32'h0, 0);
        wait_done();
        chk("lh_lit", last_rdata, 32'hFFFFDEAD);
        issue(0, 3'd5, 8'h12, 32'h0, 0);
        wait_done();
        chk("lhu_lit", last_rdata, 32'h0000DEAD);
        issue(0, 3'd0, 8'h11, 32'h0, 0);
        wait_done();
        chk("lb_lit", last_rdata, 32'hFFFFFFBE);
        issue(0, 3'd4, 8'h11, 32'h0, 0);
        wait_done();
        chk("lbu_lit", last_rdata, 32'h000000BE);

        s21 = gmem[8'h21];
        s22 = gmem[8'h22];
        s23 = gmem[8'h23];
        issue(1, 3'd0, 8'h20, 32'h12345678, 0);
        issue(0, 3'd2, 8'h20, 32'h0, 0);
        wait_done();
        chk("sb_lw_byte0", last_rdata[7:0], 8'h78);
        chk("sb_lw_upper", last_rdata[31:8], {s23, s22, s21});

        issue(0, 3'd3, 8'h00, 32'h0, 0);
        wait_done();
        chk("ld011_err", last_err, 1);
        issue(1, 3'd4, 8'h00, 32'hFFFFFFFF, 0);
        wait_done();
        chk("st100_err", last_err, 1);

        issue(1, 3'd2, 8'hFE, 32'hA1B2C3D4, 0);
        wait_done();
`ifdef LSU_ALIGN_CHECK_EN
        chk("sw_fe_err", last_err, 1);
`else
        chk("sw_fe_err", last_err, 0);
        chk("sw_fe_wrap", {mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]}, 32'hA1B2C3D4);
`endif

        s31 = gmem[8'h31];
        issue(1, 3'd2, 8'h30, 32'h55667788, 1);
        @(posedge clk);
        #1;
        apply_reset(2);
        chk("rst_mid_b0", mem[8'h30], 8'h88);
        chk("rst_mid_b1", mem[8'h31], s31);
        issue(0, 3'd0, 8'h30, 32'h0, 0);
        wait_done();
        chk("lb_after_rst", last_rdata, 32'hFFFFFF88);

        for (int t = 0; t < 250; t++) begin
            issue(1'($urandom), 3'($urandom), 8'($urandom), $urandom, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_done();

        begin
            int diffs;
            diffs = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== gmem[i]) diffs++;
            chk("mem_image_diffs", diffs, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
